// File: rtl/p_add_arb_pkg.sv
// Shared perceptron types: data configs, helpers and the
// round-robin pointer macro used by the adder arbiter.
`ifndef RR_NEXT_DEFINED
`define RR_NEXT_DEFINED
`define RrNext(ptr, N) ((int'(ptr) + 1) % (N))
`endif

package p_add_arb_pkg;

  typedef enum logic [1:0] {
    FXP,
    FLP
  } dtype_t;

  typedef struct packed {
    dtype_t     dtype;
    logic       sgn;
    logic [7:0] prec;
    logic [7:0] frac;
  } dconf_t;

  localparam dconf_t FXP_S8_3 = '{
    dtype: FXP,
    sgn:   1'b1,
    prec:  8'd8,
    frac:  8'd3
  };

  localparam dconf_t FXP_S16_4 = '{
    dtype: FXP,
    sgn:   1'b1,
    prec:  8'd16,
    frac:  8'd4
  };

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/p_add.sv
// Fixed-point adder: aligns binary points, rounds half-up
// to the result format and saturates with ovf/udf flags.
module p_add
  import p_add_arb_pkg::*;
#(
  parameter dconf_t I1_CONF = FXP_S8_3,
  parameter dconf_t I2_CONF = FXP_S16_4,
  parameter dconf_t O_CONF  = FXP_S16_4,
  localparam int P1 = int'(I1_CONF.prec),
  localparam int P2 = int'(I2_CONF.prec),
  localparam int PO = int'(O_CONF.prec)
) (
  input  logic [P1-1:0] in1,
  input  logic [P2-1:0] in2,
  output logic [PO-1:0] out,
  output logic          ovf,
  output logic          udf,
  output logic          rounded
);

  localparam int F1 = int'(I1_CONF.frac);
  localparam int F2 = int'(I2_CONF.frac);
  localparam int FO = int'(O_CONF.frac);
  localparam int FA = imax(F1, F2);
  localparam int WA = imax(P1 - F1, P2 - F2) + FA + 2;
  localparam int WR = (FO >= FA) ? WA + FO - FA
                                 : WA - (FA - FO) + 1;
  localparam int WC = imax(WR, PO) + 1;

  localparam logic signed [WC-1:0] OMAX =
    O_CONF.sgn ? WC'((64'sd1 <<< (PO - 1)) - 64'sd1)
               : WC'((64'sd1 <<< PO) - 64'sd1);
  localparam logic signed [WC-1:0] OMIN =
    O_CONF.sgn ? WC'(-(64'sd1 <<< (PO - 1)))
               : '0;

  logic                 s1;
  logic                 s2;
  logic signed [WA-1:0] a1;
  logic signed [WA-1:0] a2;
  logic signed [WA-1:0] sum;
  logic signed [WR-1:0] rv;
  logic signed [WC-1:0] rw;
  logic                 rnd;

  assign s1  = I1_CONF.sgn & in1[P1-1];
  assign s2  = I2_CONF.sgn & in2[P2-1];
  assign a1  = $signed({{(WA-P1){s1}}, in1}) <<< (FA - F1);
  assign a2  = $signed({{(WA-P2){s2}}, in2}) <<< (FA - F2);
  assign sum = a1 + a2;

  generate
    if (FO == FA) begin : g_same
      assign rv  = sum;
      assign rnd = 1'b0;
    end else if (FO > FA) begin : g_up
      assign rv  = {sum, {(FO-FA){1'b0}}};
      assign rnd = 1'b0;
    end else begin : g_down
      localparam int D = FA - FO;
      assign rnd = |sum[D-1:0];
      assign rv  = $signed({sum[WA-1], sum[WA-1:D]})
                 + $signed({{(WR-1){1'b0}}, sum[D-1]});
    end
  endgenerate

  assign rw      = WC'(rv);
  assign ovf     = rw > OMAX;
  assign udf     = rw < OMIN;
  assign rounded = rnd;

  // clamp to the result range on overflow or underflow
  always_comb begin
    out = rw[PO-1:0];
    if (ovf) out = OMAX[PO-1:0];
    else if (udf) out = OMIN[PO-1:0];
  end

endmodule

// File: rtl/p_add_arb_rr_arbiter.sv
// Combinational round-robin picker: first set request at
// or after ptr, wrapping, as one-hot and binary index.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // scan farthest-first so the nearest request wins last
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = N'(1) << ((int'(ptr) + k) % N);
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/p_add_arb.sv
// Round-robin arbiter sharing one p_add among NREQ lanes,
// with a registered result channel and imprecision count.
module p_add_arb
  import p_add_arb_pkg::*;
#(
  parameter int     NREQ    = 4,
  parameter dconf_t I1_CONF = FXP_S8_3,
  parameter dconf_t I2_CONF = FXP_S16_4,
  parameter dconf_t O_CONF  = FXP_S16_4,
  parameter int     CNT_W   = 16,
  localparam int IW = $clog2(NREQ),
  localparam int P1 = int'(I1_CONF.prec),
  localparam int P2 = int'(I2_CONF.prec),
  localparam int PO = int'(O_CONF.prec)
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0][P1-1:0]  req_in1,
  input  logic [NREQ-1:0][P2-1:0]  req_in2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IW-1:0]            out_id,
  output logic [PO-1:0]            out,
  output logic                     ovf,
  output logic                     udf,
  output logic                     rounded,
  output logic [CNT_W-1:0]         imp_cnt
);

  logic [1:0]      rsync;
  logic            rst_n;
  logic [IW-1:0]   rr_ptr;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gidx;
  logic [P1-1:0]   in1;
  logic [P2-1:0]   in2;
  logic [PO-1:0]   sum;
  logic            s_ovf;
  logic            s_udf;
  logic            s_rnd;
  logic            slot_free;
  logic            fire;

  // assert reset at once, release it two edges later
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) rsync <= 2'b00;
    else rsync <= {rsync[0], 1'b1};
  end

  assign rst_n = rsync[1];

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx)
  );

  assign in1 = req_in1[gidx];
  assign in2 = req_in2[gidx];

  p_add #(
    .I1_CONF (I1_CONF),
    .I2_CONF (I2_CONF),
    .O_CONF  (O_CONF)
  ) u_add (
    .in1     (in1),
    .in2     (in2),
    .out     (sum),
    .ovf     (s_ovf),
    .udf     (s_udf),
    .rounded (s_rnd)
  );

  assign slot_free = !out_valid | out_ready;
  assign fire      = rst_n & slot_free & (|req_valid);
  assign req_ready = fire ? gnt : '0;

  // result slot: load on fire, drop valid on a bare drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_id    <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      rounded   <= 1'b0;
      rr_ptr    <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out       <= sum;
      out_id    <= gidx;
      ovf       <= s_ovf;
      udf       <= s_udf;
      rounded   <= s_rnd;
      rr_ptr    <= IW'(`RrNext(gidx, NREQ));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // count imprecise results, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imp_cnt <= '0;
    end else if (fire && (s_ovf | s_udf | s_rnd)) begin
      if (imp_cnt != '1) imp_cnt <= imp_cnt + 1'b1;
    end
  end

endmodule
